// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the serial-to-parallel deserializer:
//   ST_COLLECT / ST_HOLD  - state encoding of the top-level FSM
//   mode_is_lsb()         - decodes the bit-order string parameter
// No ports (package).
// -----------------------------------------------------------------------------
package deser_pkg;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_HOLD    = 1'b1;

  // Only an exact "LSB_FIRST" selects LSB-first order; any other string
  // (including typos) falls back to MSB-first.
  function automatic logic mode_is_lsb(input string mode);
    logic lsb;
    if (mode == "LSB_FIRST") begin
      lsb = 1'b1;
    end else begin
      lsb = 1'b0;
    end
    return lsb;
  endfunction

endpackage

// File: rtl/deser_counter.sv
// -----------------------------------------------------------------------------
// deser_counter
// Saturating bit counter for the deserializer.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (count -> 0)
//   inc    in   count one more bit
//   clr    in   start a new word; with inc set the new word already holds 1 bit
//   count  out  current count, CNT_W bits
//   at_max out  count equals MAX
// -----------------------------------------------------------------------------
module deser_counter #(
  (* param_role = "terminal_count" *) parameter int MAX   = 8,
  (* param_role = "count_width" *)    parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign at_max = (count_q == CNT_W'(MAX));
  assign count  = count_q;

  // Next count: clear wins over increment, and the count saturates at MAX.
  always_comb begin
    count_d = count_q;
    if (clr && inc) begin
      count_d = CNT_W'(1);
    end else if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/deser_param.sv
// -----------------------------------------------------------------------------
// deser_param
// Parameterised serial-to-parallel deserializer: one bit per accepted beat,
// one WIDTH-bit word out.
// Parameters: WIDTH (1..32), MODE ("MSB_FIRST"/"LSB_FIRST"), FILL (reset
// pattern, bit i of the word resets to FILL[i mod 8]).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   serial bit present
//   in_bit     in   serial data bit
//   in_ready   out  bit accepted this cycle
//   out_valid  out  out_data holds a complete word
//   out_ready  in   consumer takes the word this cycle
//   out_data   out  assembled word
//   bit_count  out  bits collected into the current word
// -----------------------------------------------------------------------------
module deser_param
  import deser_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter string       MODE  = "MSB_FIRST",
  parameter logic [7:0]  FILL  = 8'h00,
  localparam int         CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] bit_count
);

  // Replicates the 8-bit fill byte across the whole word.
  function automatic logic [WIDTH-1:0] fill_word(input logic [7:0] f);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w[i] = f[i % 8];
    end
    return w;
  endfunction

  localparam logic [WIDTH-1:0] FILL_WORD  = fill_word(FILL);
  localparam logic             LSB_FIRST  = mode_is_lsb(MODE);
  localparam logic             SINGLE_BIT = (WIDTH == 32'd1);

  logic             state_q;
  logic             state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             accept;
  logic             take;
  logic             last_beat;
  logic             cnt_full;

  // In HOLD the producer may only push a bit when the word leaves in the same
  // cycle (bypass). The cnt_full term keeps a full word from being overrun
  // even if counter and state ever disagree.
  assign in_ready  = (state_q == ST_COLLECT) ? !cnt_full : out_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = shift_q;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign last_beat = (bit_count == CNT_W'(WIDTH - 1));

  deser_counter #(
    .MAX   (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (accept),
    .clr    (take),
    .count  (bit_count),
    .at_max (cnt_full)
  );

  // Shift-register next value: new bit enters at the far end for the chosen order.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      if (LSB_FIRST) begin
        shift_d            = shift_q >> 1;
        shift_d[WIDTH-1]   = in_bit;
      end else begin
        shift_d            = shift_q << 1;
        shift_d[0]         = in_bit;
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // FSM next state: COLLECT until WIDTH bits are in, HOLD until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept && last_beat) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (take) begin
          // A bypassed bit completes a whole new word only when WIDTH is 1.
          if (accept && SINGLE_BIT) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // State and data registers; reset reloads the fill pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      shift_q <= FILL_WORD;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_deser_param.sv
// -----------------------------------------------------------------------------
// tb_deser_param
// Directed bench for deser_param with four parameterisations:
//   u8  : defaults (WIDTH=8, MSB_FIRST, FILL=0)
//   u4  : WIDTH=4, LSB_FIRST
//   u12 : WIDTH=12, FILL=8'hA5
//   u1  : WIDTH=1
// -----------------------------------------------------------------------------
module tb_deser_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic v8 = 1'b0, b8 = 1'b0, r8 = 1'b0, ir8, ov8;
  logic [7:0] od8;
  logic [3:0] bc8;
  logic v4 = 1'b0, b4 = 1'b0, r4 = 1'b0, ir4, ov4;
  logic [3:0] od4;
  logic [2:0] bc4;
  logic v12 = 1'b0, b12 = 1'b0, r12 = 1'b0, ir12, ov12;
  logic [11:0] od12;
  logic [3:0] bc12;
  logic v1 = 1'b0, b1 = 1'b0, r1 = 1'b0, ir1, ov1;
  logic [0:0] od1;
  logic [0:0] bc1;

  deser_param u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_bit(b8), .in_ready(ir8),
    .out_valid(ov8), .out_ready(r8), .out_data(od8), .bit_count(bc8));

  deser_param #(.WIDTH(4), .MODE("LSB_FIRST")) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_bit(b4), .in_ready(ir4),
    .out_valid(ov4), .out_ready(r4), .out_data(od4), .bit_count(bc4));

  deser_param #(.WIDTH(12), .FILL(8'hA5)) u12 (
    .clk(clk), .rst(rst), .in_valid(v12), .in_bit(b12), .in_ready(ir12),
    .out_valid(ov12), .out_ready(r12), .out_data(od12), .bit_count(bc12));

  deser_param #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_bit(b1), .in_ready(ir1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .bit_count(bc1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  pat8;
    logic [11:0] pat12;
    logic [3:0]  bits4;
    logic [3:0]  bits1;

    // Reset all instances.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_u8_data", 32'(od8), 32'h00);
    chk("rst_u8_count", 32'(bc8), 32'd0);
    chk("rst_u8_valid", 32'(ov8), 32'd0);
    chk("rst_u8_ready", 32'(ir8), 32'd1);
    chk("rst_u12_fill", 32'(od12), 32'h5A5);
    chk("rst_u12_count", 32'(bc12), 32'd0);
    chk("rst_u4_ready", 32'(ir4), 32'd1);
    chk("rst_u1_valid", 32'(ov1), 32'd0);

    // Test 1: MSB-first 1,0,1,1,0,0,1,0 with out_ready low.
    pat8 = 8'b1011_0010;
    r8 = 1'b0;
    v8 = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      b8 = pat8[i];
      tick();
      if (i == 1) begin
        chk("t1_count7", 32'(bc8), 32'd7);
        chk("t1_valid_early", 32'(ov8), 32'd0);
      end
    end
    chk("t1_valid", 32'(ov8), 32'd1);
    chk("t1_data", 32'(od8), 32'hB2);
    chk("t1_count", 32'(bc8), 32'd8);
    chk("t1_ready", 32'(ir8), 32'd0);
    b8 = 1'b1;
    tick();
    chk("t1_hold_data", 32'(od8), 32'hB2);
    chk("t1_hold_count", 32'(bc8), 32'd8);
    v8 = 1'b0;
    r8 = 1'b1;
    #1;
    chk("t1_bypass_ready", 32'(ir8), 32'd1);
    tick();
    r8 = 1'b0;
    chk("t1_taken_valid", 32'(ov8), 32'd0);
    chk("t1_taken_count", 32'(bc8), 32'd0);
    chk("t1_taken_data", 32'(od8), 32'hB2);

    // Test 3: reset at bit 5 of 8, then a fresh word.
    v8 = 1'b1;
    b8 = 1'b1;
    repeat (5) tick();
    chk("t3_count5", 32'(bc8), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_rst_count", 32'(bc8), 32'd0);
    chk("t3_rst_valid", 32'(ov8), 32'd0);
    chk("t3_rst_data", 32'(od8), 32'h00);
    pat8 = 8'h55;
    for (int i = 7; i >= 0; i--) begin
      b8 = pat8[i];
      tick();
    end
    chk("t3_valid", 32'(ov8), 32'd1);
    chk("t3_data", 32'(od8), 32'h55);
    chk("t3_count", 32'(bc8), 32'd8);
    v8 = 1'b0;
    r8 = 1'b1;
    tick();
    r8 = 1'b0;

    // Test 6: in_valid toggling; only accepted beats count.
    pat8 = 8'hCF;
    for (int i = 7; i >= 0; i--) begin
      v8 = 1'b1;
      b8 = pat8[i];
      tick();
      chk("t6_count_beat", 32'(bc8), 32'(8 - i));
      if (i != 0) begin
        v8 = 1'b0;
        b8 = ~pat8[i];
        tick();
        chk("t6_count_gap", 32'(bc8), 32'(8 - i));
        chk("t6_valid_gap", 32'(ov8), 32'd0);
      end
    end
    v8 = 1'b0;
    chk("t6_valid", 32'(ov8), 32'd1);
    chk("t6_data", 32'(od8), 32'hCF);
    r8 = 1'b1;
    tick();
    r8 = 1'b0;

    // Test 2: WIDTH=4 LSB-first 1,1,0,1 then bypass into the next word.
    bits4 = 4'b1011;
    r4 = 1'b0;
    v4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4 = bits4[i];
      tick();
    end
    chk("t2_valid", 32'(ov4), 32'd1);
    chk("t2_data", 32'(od4), 32'hB);
    chk("t2_count", 32'(bc4), 32'd4);
    r4 = 1'b1;
    b4 = 1'b1;
    tick();
    r4 = 1'b0;
    chk("t2_bypass_valid", 32'(ov4), 32'd0);
    chk("t2_bypass_count", 32'(bc4), 32'd1);
    chk("t2_bypass_data", 32'(od4), 32'hD);
    chk("t2_bypass_ready", 32'(ir4), 32'd1);
    bits4 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      b4 = bits4[i];
      tick();
    end
    chk("t2_word2_valid", 32'(ov4), 32'd1);
    chk("t2_word2_data", 32'(od4), 32'h9);
    chk("t2_word2_count", 32'(bc4), 32'd4);
    v4 = 1'b0;
    r4 = 1'b1;
    tick();
    r4 = 1'b0;

    // Test 4: WIDTH=12 word then 10 cycles of back-pressure.
    pat12 = 12'hAC3;
    r12 = 1'b0;
    v12 = 1'b1;
    for (int i = 11; i >= 0; i--) begin
      b12 = pat12[i];
      tick();
    end
    chk("t4_valid", 32'(ov12), 32'd1);
    chk("t4_data", 32'(od12), 32'hAC3);
    chk("t4_count", 32'(bc12), 32'd12);
    for (int i = 0; i < 10; i++) begin
      b12 = i[0];
      tick();
      chk("t4_bp_data", 32'(od12), 32'hAC3);
      chk("t4_bp_ready", 32'(ir12), 32'd0);
    end
    v12 = 1'b0;
    r12 = 1'b1;
    tick();
    r12 = 1'b0;
    chk("t4_taken_valid", 32'(ov12), 32'd0);

    // Test 5: WIDTH=1 streaming 0,1,1,0 with out_ready high.
    bits1 = 4'b0110;
    r1 = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b1 = bits1[i];
      tick();
      chk("t5_valid", 32'(ov1), 32'd1);
      chk("t5_data", 32'(od1), 32'(bits1[i]));
      chk("t5_count", 32'(bc1), 32'd1);
    end
    v1 = 1'b0;
    tick();
    chk("t5_drain_valid", 32'(ov1), 32'd0);
    chk("t5_drain_count", 32'(bc1), 32'd0);
    r1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
